// File: rtl/ashleyjr_delay_line.sv
// rtl/ashleyjr_delay_line.sv - 64 x 8 circular-buffer delay line, 1..64 cycle programmable latency
// Optional macro DELAY_LINE_STATUS_EN drives a "buffer primed" flag on uio_out[7].
module ashleyjr_delay_line (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int DEPTH = 64;

  logic [7:0] mem [DEPTH];
  logic [5:0] wp;
  logic [5:0] dly;
  logic [5:0] rd_idx;
  logic       load;
  logic [5:0] load_val;

  assign load     = uio_in[6];
  assign load_val = uio_in[5:0];

  // Six-bit subtraction wraps naturally, giving (wp - D) mod 64.
  assign rd_idx = wp - dly;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= 8'h00;
      end
      wp     <= 6'd0;
      dly    <= 6'd0;
      uo_out <= 8'h00;
    end else if (ena) begin
      mem[wp] <= ui_in;
      wp      <= wp + 6'd1;
      // D == 0 bypasses the buffer: the slot at wp is being written this edge.
      uo_out  <= (dly == 6'd0) ? ui_in : mem[rd_idx];
      if (load) begin
        dly <= load_val;
      end
    end
  end

`ifdef DELAY_LINE_STATUS_EN
  logic [6:0] fc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fc <= 7'd0;
    end else if (ena && (fc != 7'd64)) begin
      fc <= fc + 7'd1;
    end
  end

  assign uio_oe  = 8'h80;
  assign uio_out = {(fc == 7'd64), 7'b0};
`else
  assign uio_oe  = 8'h00;
  assign uio_out = 8'h00;
`endif

  // uio_in[7] is a pin with no function in either build.
  logic unused_status_pin;
  assign unused_status_pin = uio_in[7];

endmodule

// File: tb/tb_ashleyjr_delay_line.sv
// tb/tb_ashleyjr_delay_line.sv - randomized self-checking bench for ashleyjr_delay_line
module tb_ashleyjr_delay_line;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'h00;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: every sample written since reset, current delay, fill count.
  logic [7:0] hist[$];
  int         m_d = 0;
  int         m_fc = 0;
  logic [7:0] exp_out = 8'h00;

  ashleyjr_delay_line dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_status();
`ifdef DELAY_LINE_STATUS_EN
    check("uio_oe", uio_oe, 8'h80);
    check("uio_out", uio_out, (m_fc == 64) ? 8'h80 : 8'h00);
`else
    check("uio_oe", uio_oe, 8'h00);
    check("uio_out", uio_out, 8'h00);
`endif
  endtask

  // Output after an enabled edge is the sample taken D edges earlier (0 before the buffer fills).
  task automatic step(input logic en, input logic [7:0] data, input logic [7:0] ctl);
    int k;
    ena = en;
    ui_in = data;
    uio_in = ctl;
    @(posedge clk);
    #1;
    if (en) begin
      k = hist.size();
      if (m_d == 0)       exp_out = data;
      else if (k >= m_d)  exp_out = hist[k - m_d];
      else                exp_out = 8'h00;
      hist.push_back(data);
      if (ctl[6]) m_d = int'(ctl[5:0]);
      if (m_fc < 64) m_fc++;
    end
    check("uo_out", uo_out, exp_out);
    check_status();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    hist.delete();
    m_d = 0;
    m_fc = 0;
    exp_out = 8'h00;
    check("rst_uo_out", uo_out, 8'h00);
    check_status();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // Pass-through with D = 0.
    step(1'b1, 8'hA5, 8'h00);
    check("passthru_a5", uo_out, 8'hA5);

    // D = 5 on a fresh buffer, then a ramp.
    do_reset();
    step(1'b1, 8'h00, 8'h45);
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 8'(i), 8'h00);
      if (i == 7) check("d5_ramp7", uo_out, 8'h02);
      if (i == 3) check("d5_early_zero", uo_out, 8'h00);
    end

    // Maximum delay across pointer wrap; status flips on the 64th enabled edge.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      step(1'b1, 8'(i + 1), (i == 0) ? 8'h7F : 8'h00);
`ifdef DELAY_LINE_STATUS_EN
      if (i == 62) check("primed_63", uio_out[7], 1'b0);
      if (i == 63) check("primed_64", uio_out[7], 1'b1);
`endif
    end

    // Mid-stream delay change 10 -> 2 with non-zero data.
    step(1'b1, 8'h11, 8'h4A);
    for (int i = 0; i < 30; i++) step(1'b1, 8'(8'h20 + i) | 8'h01, 8'h00);
    step(1'b1, 8'h81, 8'h42);
    step(1'b1, 8'h83, 8'h00);
    check("d2_tap", uo_out, 8'h3D);
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'h90 + i), 8'h00);

    // Enable low for 7 cycles with changing data and load strobes.
    for (int i = 0; i < 7; i++) step(1'b0, 8'($urandom), 8'h40 | 8'($urandom_range(0, 63)));
    for (int i = 0; i < 10; i++) step(1'b1, 8'(8'hB0 + i), 8'h00);

    // Randomized run with occasional loads, enable drops and mid-run resets.
    for (int i = 0; i < 3000; i++) begin
      logic [7:0] ctl;
      ctl = 8'($urandom) & 8'hBF;
      if ($urandom_range(0, 15) == 0) ctl[6] = 1'b1;
      step($urandom_range(0, 9) != 0, 8'($urandom), ctl);
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    // Reset asserted mid-run clears output and status at once.
    do_reset();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ashleyjr_delay_line.md
# ashleyjr_delay_line

Programmable digital delay line for the TinyTapeout harness. An 8-bit input word is sampled every enabled clock and reappears on the dedicated outputs a programmable 1..64 cycles later. It is built as a 64-entry circular buffer with a runtime-loadable tap offset. It sits directly on the standard `tt_um_*` user-project pin set.

## Interface
- No parameters. Depth is fixed at 64 entries × 8 bits; the delay field is 6 bits.
- One clock; reset is asynchronous and active-low.
- `clk`  in  1  system clock; all state is updated on its rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `ena`  in  1  design selected; while low, all state holds.
- `ui_in`  in  8  data word, sampled every enabled edge.
- `uo_out`  out  8  delayed data word, registered.
- `uio_in`  in  8  control inputs:
  - `[5:0]` delay value D.
  - `[6]` load strobe.
  - `[7]` status pin (see Configuration).
- `uio_out`  out  8  status outputs (see Configuration).
- `uio_oe`  out  8  bidirectional-pin output enables; 1 = the pin is an output.

## Operation
- State:
  - `buf[0:63]` × 8 bits.
  - Write pointer `wp` (6 bits).
  - Delay register `D` (6 bits).
  - `uo_out` register.
  - Fill counter `fc` (7 bits, saturating at 64).
- Reset (`rst_n`=0) clears `buf` entries, `wp`, `D`, `uo_out` and `fc` to 0.
- On each rising edge with `ena`=1, these happen in parallel and all use pre-edge values:
  - `buf[wp]` ← `ui_in`.
  - `wp` ← `wp`+1, modulo 64; wraps from 63 to 0.
  - `uo_out` ← `ui_in` if D==0, else `buf[(wp−D) mod 64]`.
  - If `uio_in[6]`=1: `D` ← `uio_in[5:0]`.
  - `fc` ← min(`fc`+1, 64).
- Resulting latency: `uo_out` after edge k equals the `ui_in` sampled at edge k−D. With the output register included, total delay is D+1 cycles, from 1 to 64.
- Until D+1 samples have been written since reset, `uo_out` shows 0, because the buffer is cleared.
- Delay change:
  - The new `D` takes effect on the edge after the load edge.
  - No flush is performed. Output jumps immediately to the new tap, using buffer content already present.
- A load strobe held high reloads `D` every edge; the last value wins.
- With `ena`=0 nothing changes: no write, no pointer advance, no load, and `uo_out` holds.
- Reset asserted mid-stream clears everything immediately. The first edge after release writes entry 0.

## Timing
- Single clock domain; no combinational path from inputs to `uo_out`.
- Input-to-output latency is D+1 rising edges of `clk` while `ena`=1.
- Control (`uio_in`) is sampled on the same edge as data.
- Reset values:
  - `uo_out`=0x00.
  - `uio_out`=0x00.
  - `uio_oe`=0x00, or 0x80 with the macro defined.

## Configuration
- Macro `DELAY_LINE_STATUS_EN`.
- Defined:
  - `uio_oe`=0x80.
  - `uio_out[7]` = 1 when `fc`==64 (buffer fully primed), else 0.
  - `uio_out[6:0]`=0.
  - `uio_in[7]` is ignored.
- Undefined:
  - `uio_oe`=0x00 and `uio_out`=0x00 constantly.
  - `fc` is not implemented.

## Test plan
- Reset and pass-through:
  - After reset, `uo_out`=0x00.
  - With D=0, drive `ui_in`=0xA5 for one edge → `uo_out`=0xA5 after that edge.
- Delay 5:
  - Load D=5 (`uio_in`=0x45 for one edge).
  - Drive the ramp 0x01, 0x02, 0x03, … → `uo_out` after the edge sampling 0x07 equals 0x02.
  - Before that, `uo_out` shows 0 for the first samples.
- Max delay and wrap:
  - Load D=63; stream 200 incrementing bytes → `uo_out` after the edge sampling byte n equals byte n−63.
  - Correct across `wp` wrap.
- Mid-stream change:
  - Streaming with D=10, load D=2 → one edge later, output equals the input from 2 edges back, with no glitch to 0.
- Enable hold:
  - Drop `ena` for 7 cycles while changing `ui_in` and strobing load → `uo_out`, `D` and `wp` unchanged.
  - The stream resumes seamlessly once `ena` returns high.
- Status (macro defined):
  - `uio_out[7]`=0 after 63 enabled edges, and 1 after the 64th.
  - Reset asserted mid-run → `uio_out[7]`=0 and `uo_out`=0 immediately.
